uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clock cycles per serial bit; legal range >= 2.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 in_data  input  DATA_BITS  byte to transmit; sampled only on handshake.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  controller accepts a byte this cycle.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  frame in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse on frame completion.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-014 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL count 0..CLKS_PER_BIT-1 in every non-IDLE state, and SHALL generate a bit-end tick at CLKS_PER_BIT-1, then wrap to 0.
REQ-015 in_ready SHALL equal (state == IDLE) and rst high; a handshake is in_valid && in_ready at a rising edge.
REQ-016 On handshake, in_data SHALL be captured into a shift register, the FSM SHALL go to START, and tx SHALL go low at that same edge.
REQ-017 Changes on in_data or in_valid after the handshake SHALL NOT affect the frame in progress.
REQ-018 Each bit (start, data, parity, stop) SHALL drive tx for exactly CLKS_PER_BIT cycles.
REQ-019 START SHALL drive tx = 0; on the tick, the FSM SHALL go to DATA.
REQ-020 DATA SHALL send the captured bits LSB first; a bit counter SHALL count 0..DATA_BITS-1, and on the tick of the last bit the FSM SHALL go to PAR if PARITY != 0, otherwise to STOP.
REQ-021 PAR SHALL drive tx = XOR of the captured data for even parity, or its inverse for odd parity; on the tick, the FSM SHALL go to STOP.
REQ-022 STOP SHALL drive tx = 1 for STOP_BITS bit periods, then go to IDLE.
REQ-023 done SHALL be high for exactly the first IDLE cycle after STOP; in_ready SHALL also be high in that cycle.
REQ-024 A back-to-back byte accepted in the done cycle SHALL start its start bit at that edge, giving exactly one idle-high cycle between frames.
REQ-025 Total frame duration from handshake edge to the done edge SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-026 in_valid asserted while busy SHALL NOT be accepted, SHALL NOT be lost by the source (held by the handshake), and SHALL be accepted in the done cycle.
REQ-027 Illegal parameter values SHALL raise an elaboration-time error.

Reset
REQ-028 While rst is low at a rising edge, the controller SHALL set state = IDLE, tx = 1, busy = 0, done = 0, in_ready = 0, and clear the baud counter, bit counter and shift register.
REQ-029 Reset asserted mid-frame SHALL abort the frame at the next edge with no done pulse; tx SHALL return high.
REQ-030 The first handshake SHALL be possible in the first cycle after rst goes high.

Verification (CLKS_PER_BIT = 4, DATA_BITS = 8, STOP_BITS = 1 unless noted)
REQ-031 PARITY = 0, send 0xA5 -> tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; done pulses 40 cycles after the handshake edge; busy is high for those 40 cycles.
REQ-032 PARITY = 2, send 0xA5 -> parity bit 0; PARITY = 1, send 0xA5 -> parity bit 1; done at 44 cycles.
REQ-033 STOP_BITS = 2, send 0x00 -> tx low for 36 cycles, then high for 8 cycles; done at 44 cycles.
REQ-034 in_valid held high with 0x55 then 0x0F -> the second byte is accepted exactly in the done cycle of the first, with one idle-high cycle between frames; in_ready = 0 throughout each frame.
REQ-035 rst low at cycle 10 of a frame -> tx = 1, busy = 0, no done pulse; after release, a new byte transmits correctly.
REQ-036 Change in_data during a frame -> the transmitted bits match the byte captured at the handshake.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one DATA_BITS word per handshake as start, data (LSB first), optional parity, stop bits.
// Latency: tx drops for the start bit on the handshake edge; done pulses (1+DATA_BITS+parity+STOP_BITS)*CLKS_PER_BIT cycles later.
// Backpressure: in_ready is high only in IDLE (including the done cycle), so a held in_valid waits for the current frame to finish.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-low reset
//   in_data   - word to send, captured only on in_valid && in_ready
//   in_valid  - source has a word
//   in_ready  - controller can accept a word this cycle
//   tx        - registered serial line, idle high
//   busy      - a frame is in progress
//   done      - one-cycle pulse in the first idle cycle after the last stop bit

module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    // Parameter legality
    if (CLKS_PER_BIT < 2) begin : g_err_clks
        $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
        $error("uart_tx_ctrl: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
        $error("uart_tx_ctrl: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    // Odd parity is the complement of the data XOR
    localparam logic          ODD_FLIP  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_baud;
    logic [BW-1:0]          r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_tick;
    logic                   w_hs;

    assign w_tick   = (r_baud == BAUD_LAST);
    assign in_ready = (r_state == S_IDLE) && rst;
    assign w_hs     = in_valid && in_ready;

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Baud counter runs in every non-idle state and wraps on the bit-end tick
            if (r_state == S_IDLE || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        // Parity is fixed at capture so later in_data changes cannot leak in
                        r_shift <= in_data;
                        r_par   <= (^in_data) ^ ODD_FLIP;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + BW'(1);
                        end
                    end
                end

                S_PAR: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_bit   <= '0;
                        r_state <= S_STOP;
                    end
                end

                S_STOP: begin
                    // Bit counter is reused to count stop-bit periods
                    if (w_tick) begin
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: four instances covering no/odd/even parity and two stop bits.
// Latency: frames are checked cycle by cycle against a bit-list model of the serial frame.
// Backpressure: in_valid is held across frames to exercise acceptance in the done cycle.

module tb_uart_tx_ctrl;

    localparam int C  = 4;
    localparam int D  = 8;
    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] in_data [NI];
    logic [3:0] rdy_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int vectors    = 0;
    int miscompares = 0;

    logic cap_tx [0:63];

    always #5 clk = ~clk;

    // Instance 0: no parity, 1 stop; 1: odd, 1 stop; 2: even, 1 stop; 3: no parity, 2 stop
    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_ctrl #(
            .CLKS_PER_BIT(C),
            .DATA_BITS   (D),
            .PARITY      (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .STOP_BITS   (g == 3 ? 2 : 1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .in_data (in_data[g]),
            .in_valid(in_valid[g]),
            .in_ready(rdy_w[g]),
            .tx      (tx_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int par_of(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int nbits(input int k);
        return 1 + D + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
    endfunction

    // Value of serial bit b of the frame carrying d on instance k
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
        int ones;
        if (b == 0) return 1'b0;
        if (b <= D) return d[b-1];
        if (par_of(k) != 0 && b == D + 1) begin
            ones = $countones(d);
            if (par_of(k) == 2) return (ones % 2) == 1;
            return (ones % 2) == 0;
        end
        return 1'b1;
    endfunction

    // Sends d on instance k starting at a negedge; ends at the negedge inside the done cycle.
    task automatic run_frame(input int k, input logic [7:0] d, input bit hold, input logic [7:0] nd);
        int n;
        n = nbits(k) * C;
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        #1;
        vectors++;
        if (rdy_w[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready inst%0d got %b want 1", k, rdy_w[k]);
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            in_data[k] = nd;
        end else begin
            in_valid[k] = 1'b0;
            in_data[k]  = 8'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            logic e;
            e = exp_bit(k, d, i / C);
            cap_tx[i] = tx_w[k];
            vectors++;
            if ({tx_w[k], busy_w[k], done_w[k], rdy_w[k]} !== {e, 3'b100}) begin
                miscompares++;
                $display("FAIL frame inst%0d byte %h cyc %0d got tx/busy/done/rdy=%b%b%b%b want %b100",
                         k, d, i, tx_w[k], busy_w[k], done_w[k], rdy_w[k], e);
            end
            @(negedge clk);
        end
        vectors++;
        if ({tx_w[k], busy_w[k], done_w[k], rdy_w[k]} !== 4'b1011) begin
            miscompares++;
            $display("FAIL done_cycle inst%0d byte %h got tx/busy/done/rdy=%b%b%b%b want 1011",
                     k, d, tx_w[k], busy_w[k], done_w[k], rdy_w[k]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 4'b0001;   // must be ignored while in reset
        for (int k = 0; k < NI; k++) in_data[k] = 8'hFF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({tx_w[k], busy_w[k], done_w[k], rdy_w[k]} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_state inst%0d got tx/busy/done/rdy=%b%b%b%b want 1000",
                         k, tx_w[k], busy_w[k], done_w[k], rdy_w[k]);
            end
        end
        in_valid = 4'b0000;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [9:0] seen;
        // First handshake in the first cycle after reset release
        run_frame(0, 8'hA5, 1'b0, 8'h00);
        for (int b = 0; b < 10; b++) seen[b] = cap_tx[b * C + C / 2];
        vectors++;
        if (seen !== 10'b1101001010) begin
            miscompares++;
            $display("FAIL basic_a5_bits got %b want 1101001010", seen);
        end
    endtask

    task automatic test_parity();
        @(negedge clk);
        run_frame(1, 8'hA5, 1'b0, 8'h00);
        vectors++;
        if (cap_tx[9 * C + 1] !== 1'b1) begin
            miscompares++;
            $display("FAIL odd_parity_a5 got %b want 1", cap_tx[9 * C + 1]);
        end
        @(negedge clk);
        run_frame(2, 8'hA5, 1'b0, 8'h00);
        vectors++;
        if (cap_tx[9 * C + 1] !== 1'b0) begin
            miscompares++;
            $display("FAIL even_parity_a5 got %b want 0", cap_tx[9 * C + 1]);
        end
    endtask

    task automatic test_stop2();
        int lows;
        int tail_highs;
        lows = 0;
        tail_highs = 0;
        @(negedge clk);
        run_frame(3, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 44; i++) begin
            if (cap_tx[i] === 1'b0) lows++;
            if (i >= 36 && cap_tx[i] === 1'b1) tail_highs++;
        end
        vectors++;
        if (lows !== 36) begin
            miscompares++;
            $display("FAIL stop2_low_cycles got %0d want 36", lows);
        end
        vectors++;
        if (tail_highs !== 8) begin
            miscompares++;
            $display("FAIL stop2_high_tail got %0d want 8", tail_highs);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_frame(0, 8'h55, 1'b1, 8'h0F);
        run_frame(0, 8'h0F, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        @(negedge clk);
        in_data[0]  = 8'h3C;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_data[0]  = 8'hC3;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({tx_w[0], busy_w[0], done_w[0], rdy_w[0]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_reset_abort got tx/busy/done/rdy=%b%b%b%b want 1000",
                     tx_w[0], busy_w[0], done_w[0], rdy_w[0]);
        end
        rst = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk);
            if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b100) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL after_abort_idle got %0d bad cycles want 0", bad);
        end
        run_frame(0, 8'($urandom), 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            int k;
            int chain;
            int gap;
            logic [7:0] d;
            logic [7:0] nd;
            k     = $urandom_range(0, NI - 1);
            chain = $urandom_range(1, 3);
            gap   = $urandom_range(0, 3);
            d     = 8'($urandom);
            @(negedge clk);
            for (int c = 0; c < chain; c++) begin
                nd = 8'($urandom);
                run_frame(k, d, (c < chain - 1), nd);
                d = nd;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                vectors++;
                if ({tx_w[k], busy_w[k], done_w[k], rdy_w[k]} !== 4'b1001) begin
                    miscompares++;
                    $display("FAIL idle_gap inst%0d got tx/busy/done/rdy=%b%b%b%b want 1001",
                             k, tx_w[k], busy_w[k], done_w[k], rdy_w[k]);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
